intersection_scheduler: RTL and testbench
=========================================

# intersection_scheduler

Two-road intersection phase scheduler. Sequences main-road and side-road signal heads through green/yellow/all-red phases, driven by a 1 s tick enable. Main road rests in green; a latched side-road vehicle or pedestrian request takes the side road through one fixed green phase. Sits above the per-road light decoders and drives both heads plus a shared seconds-remaining countdown.

## Interface
Parameters:
- MAIN_G_T, 4'd10, minimum main green, seconds
- SIDE_G_T, 4'd8, side green, seconds
- Y_T, 4'd3, yellow, seconds (both roads)
- ALLR_T, 4'd2, all-red clearance, seconds (also the startup phase)

Ports:
- sys_clk  in  1  system clock
- sys_rst_p  in  1  reset; one clock, reset is synchronous and active-high
- tick_1s  in  1  one-sys_clk-wide pulse, once per second
- side_req  in  1  side-road vehicle sensor, level
- ped_req  in  1  pedestrian button, any width ≥1 cycle
- main_light  out  3  one-hot {R,Y,G}: 3'b001 G, 3'b010 Y, 3'b100 R
- side_light  out  3  same encoding
- light_t  out  4  seconds remaining in current phase
- ped_walk  out  1  walk indication, high only during SIDE_G

## Operation
- States: STARTUP, MAIN_G, MAIN_Y, ALLR_MS, SIDE_G, SIDE_Y, ALLR_SM.
- Order: STARTUP→MAIN_G→MAIN_Y→ALLR_MS→SIDE_G→SIDE_Y→ALLR_SM→MAIN_G.
- Heads: MAIN_G main G/side R; MAIN_Y main Y/side R; SIDE_G main R/side G; SIDE_Y main R/side Y; STARTUP, ALLR_* both R.
- Entering a phase loads light_t with its duration. A parameter value of 0 loads 1.
- On each tick_1s: if light_t > 1, light_t decrements. If light_t == 1, the phase ends and the next phase is entered.
- Exception: MAIN_G with light_t == 1 and no pending request holds. light_t stays at 1 and heads stay unchanged.
- side_pend is set on any cycle with side_req high while the state is not SIDE_G.
- ped_pend is set on any cycle with ped_req high while the state is not SIDE_G.
- Both side_pend and ped_pend clear in the cycle SIDE_G is entered; clear wins over a same-cycle set.
- MAIN_G with light_t == 1 exits on a tick when (side_pend | ped_pend) is high, including a request set in that same tick cycle.
- Requests that arrive during SIDE_Y or ALLR_SM stay latched. They force the next cycle after main minimum green expires.
- ped_walk = (state == SIDE_G) & ped_served, where ped_served is captured from ped_pend at SIDE_G entry.

## Timing
- All outputs are registered. A tick sampled in cycle n changes outputs at n+1.
- With no tick, all state is held.
- Reset values: state STARTUP, main_light 3'b100, side_light 3'b100, light_t = ALLR_T, ped_walk 0, side_pend 0, ped_pend 0.
- sys_rst_p high mid-phase returns to these values on the next edge. It overrides a simultaneous tick.
- Phase length is exactly N ticks for duration N. The full cycle is MAIN_G_T(min) + 2·Y_T + 2·ALLR_T + SIDE_G_T ticks.
- tick_1s high on consecutive cycles counts each cycle as one tick; no filtering.

## Configuration
- PED_WALK_EN defined: the ped_pend/ped_served logic is built as described.
- PED_WALK_EN undefined: ped_req is ignored, ped_walk is constant 0, and only side_pend triggers the side phase. Ports are unchanged.

## Structure
- Shared package traffic_pkg holds:
  - state encoding localparams (one-hot, 7 bits)
  - light encodings LIGHT_G / LIGHT_Y / LIGHT_R
  - the 4-bit time type width
- One sub-module, phase_timer: loadable 4-bit down-counter with tick enable.
  - Inputs: load, load_val, tick.
  - Outputs: count, last (count == 1).
  - Instantiated once.
- The scheduler FSM, request latches and head decode live in intersection_scheduler.

## Test plan
- Reset then 2 ticks → light_t 2→1→MAIN_G with light_t 10, main 3'b001, side 3'b100.
- No requests, 20 ticks in MAIN_G → light_t reaches 1 after 9 ticks and holds, heads unchanged.
- side_req pulse at light_t 6 → at the tick with light_t == 1, MAIN_Y with light_t 3, then ALLR_MS 2, SIDE_G 8 (side 3'b001), SIDE_Y 3, ALLR_SM 2, then MAIN_G 10. ped_walk stays 0 throughout.
- ped_req asserted in the same cycle as the final MAIN_G tick → MAIN_Y is entered; SIDE_G has ped_walk 1 for 8 ticks. With PED_WALK_EN undefined: stays in MAIN_G, ped_walk 0.
- side_req held high through SIDE_G → no re-latch during SIDE_G; after returning to MAIN_G, still one full 10-tick main green before the next exit.
- sys_rst_p asserted mid SIDE_G with tick_1s high → next cycle STARTUP, both heads red, light_t 2, pending requests cleared.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and encodings for the intersection scheduler: one-hot phase
// states, signal-head encodings and the seconds-remaining time type.
package traffic_pkg;

   localparam int T_W = 4;
   typedef logic [T_W-1:0] time_t;

   localparam logic [6:0] S_STARTUP = 7'b000_0001;
   localparam logic [6:0] S_MAIN_G  = 7'b000_0010;
   localparam logic [6:0] S_MAIN_Y  = 7'b000_0100;
   localparam logic [6:0] S_ALLR_MS = 7'b000_1000;
   localparam logic [6:0] S_SIDE_G  = 7'b001_0000;
   localparam logic [6:0] S_SIDE_Y  = 7'b010_0000;
   localparam logic [6:0] S_ALLR_SM = 7'b100_0000;

   typedef enum logic [6:0] {
      STARTUP = S_STARTUP,
      MAIN_G  = S_MAIN_G,
      MAIN_Y  = S_MAIN_Y,
      ALLR_MS = S_ALLR_MS,
      SIDE_G  = S_SIDE_G,
      SIDE_Y  = S_SIDE_Y,
      ALLR_SM = S_ALLR_SM
   } state_e;

   localparam logic [2:0] LIGHT_G = 3'b001;
   localparam logic [2:0] LIGHT_Y = 3'b010;
   localparam logic [2:0] LIGHT_R = 3'b100;

   // A zero-length phase would never see light_t == 1, so it runs for one tick.
   function automatic time_t dur_fix(input time_t d);
      return (d == 4'd0) ? 4'd1 : d;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable 4-bit seconds down-counter; decrements on tick while above 1 and
// parks at 1 until reloaded.
module phase_timer
   import traffic_pkg::*;
#(
   parameter time_t RST_VAL = 4'd2
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  load_i,
   input  time_t load_val_i,
   input  logic  tick_i,
   output time_t count_o,
   output logic  last_o
);

   time_t count_q, count_d;

   // Next count: load wins over tick; a count of 1 is held.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (tick_i && (count_q > 4'd1)) begin
         count_d = count_q - 4'd1;
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= RST_VAL;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign last_o  = (count_q == 4'd1);

endmodule

// File: rtl/intersection_scheduler.sv
// Two-road intersection phase scheduler: FSM, request latches and head decode.
// Optional pedestrian walk support is built when PED_WALK_EN is defined.
module intersection_scheduler
   import traffic_pkg::*;
#(
   parameter time_t MAIN_G_T = 4'd10,
   parameter time_t SIDE_G_T = 4'd8,
   parameter time_t Y_T      = 4'd3,
   parameter time_t ALLR_T   = 4'd2
) (
   input  logic       sys_clk,
   input  logic       sys_rst_p,
   input  logic       tick_1s,
   input  logic       side_req,
   input  logic       ped_req,
   output logic [2:0] main_light,
   output logic [2:0] side_light,
   output time_t      light_t,
   output logic       ped_walk
);

   state_e     state_q, state_d, nxt_s;
   time_t      nxt_dur_s;
   logic [2:0] main_q, main_d, side_q, side_d;
   logic       side_pend_q, side_pend_d;
   logic       walk_q, walk_d;
   logic       last_s, go_s, enter_side_s, req_now_s, ped_hit_s;

   phase_timer #(.RST_VAL(dur_fix(ALLR_T))) u_timer (
      .clk_i      (sys_clk),
      .rst_i      (sys_rst_p),
      .load_i     (go_s),
      .load_val_i (nxt_dur_s),
      .tick_i     (tick_1s),
      .count_o    (light_t),
      .last_o     (last_s)
   );

`ifdef PED_WALK_EN
   logic ped_pend_q, ped_pend_d, ped_served_q, ped_served_d;
   assign ped_hit_s = ped_pend_q | (ped_req & (state_q != SIDE_G));
`else
   logic unused_ped_s;
   assign unused_ped_s = ped_req;
   assign ped_hit_s    = 1'b0;
`endif

   // Requests seen this cycle count toward the MAIN_G exit decision.
   assign req_now_s = side_pend_q | (side_req & (state_q != SIDE_G)) | ped_hit_s;

   // Successor phase, advance decision and head decode of the next state.
   always_comb begin
      nxt_s     = STARTUP;
      nxt_dur_s = dur_fix(ALLR_T);
      case (state_q)
         STARTUP: begin nxt_s = MAIN_G;  nxt_dur_s = dur_fix(MAIN_G_T); end
         MAIN_G:  begin nxt_s = MAIN_Y;  nxt_dur_s = dur_fix(Y_T);      end
         MAIN_Y:  begin nxt_s = ALLR_MS; nxt_dur_s = dur_fix(ALLR_T);   end
         ALLR_MS: begin nxt_s = SIDE_G;  nxt_dur_s = dur_fix(SIDE_G_T); end
         SIDE_G:  begin nxt_s = SIDE_Y;  nxt_dur_s = dur_fix(Y_T);      end
         SIDE_Y:  begin nxt_s = ALLR_SM; nxt_dur_s = dur_fix(ALLR_T);   end
         ALLR_SM: begin nxt_s = MAIN_G;  nxt_dur_s = dur_fix(MAIN_G_T); end
         default: begin nxt_s = STARTUP; nxt_dur_s = dur_fix(ALLR_T);   end
      endcase

      go_s = tick_1s & last_s & ((state_q != MAIN_G) | req_now_s);
      if (go_s) begin
         state_d = nxt_s;
      end else begin
         state_d = state_q;
      end
      enter_side_s = go_s & (nxt_s == SIDE_G);

      main_d = LIGHT_R;
      side_d = LIGHT_R;
      case (state_d)
         MAIN_G:  begin main_d = LIGHT_G; side_d = LIGHT_R; end
         MAIN_Y:  begin main_d = LIGHT_Y; side_d = LIGHT_R; end
         SIDE_G:  begin main_d = LIGHT_R; side_d = LIGHT_G; end
         SIDE_Y:  begin main_d = LIGHT_R; side_d = LIGHT_Y; end
         default: begin main_d = LIGHT_R; side_d = LIGHT_R; end
      endcase
   end

   // Request latches; entering SIDE_G clears them ahead of any same-cycle set.
   always_comb begin
      side_pend_d = side_pend_q | (side_req & (state_q != SIDE_G));
      if (enter_side_s) begin
         side_pend_d = 1'b0;
      end else begin
         side_pend_d = side_pend_q | (side_req & (state_q != SIDE_G));
      end
`ifdef PED_WALK_EN
      ped_pend_d   = ped_hit_s;
      ped_served_d = ped_served_q;
      if (enter_side_s) begin
         ped_pend_d   = 1'b0;
         ped_served_d = ped_hit_s;
      end else begin
         ped_pend_d   = ped_hit_s;
         ped_served_d = ped_served_q;
      end
      walk_d = (state_d == SIDE_G) & ped_served_d;
`else
      walk_d = 1'b0;
`endif
   end

   // State, heads, walk and request registers.
   always_ff @(posedge sys_clk) begin
      if (sys_rst_p) begin
         state_q     <= STARTUP;
         main_q      <= LIGHT_R;
         side_q      <= LIGHT_R;
         walk_q      <= 1'b0;
         side_pend_q <= 1'b0;
`ifdef PED_WALK_EN
         ped_pend_q   <= 1'b0;
         ped_served_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         side_q      <= side_d;
         walk_q      <= walk_d;
         side_pend_q <= side_pend_d;
`ifdef PED_WALK_EN
         ped_pend_q   <= ped_pend_d;
         ped_served_q <= ped_served_d;
`endif
      end
   end

   assign main_light = main_q;
   assign side_light = side_q;
   assign ped_walk   = walk_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Table-driven bench for intersection_scheduler with default phase durations;
// expectations adapt to whether PED_WALK_EN is defined.
module tb_intersection_scheduler;

   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] R = 3'b100;

   logic       sys_clk = 1'b0;
   logic       sys_rst_p = 1'b1;
   logic       tick_1s = 1'b0;
   logic       side_req = 1'b0;
   logic       ped_req = 1'b0;
   logic [2:0] main_light, side_light;
   logic [3:0] light_t;
   logic       ped_walk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic       rst, tick, sreq, preq;
      logic [2:0] em, es;
      logic [3:0] et;
      logic       ew;
   } vec_t;

   vec_t vq[$];

   intersection_scheduler dut (
      .sys_clk    (sys_clk),
      .sys_rst_p  (sys_rst_p),
      .tick_1s    (tick_1s),
      .side_req   (side_req),
      .ped_req    (ped_req),
      .main_light (main_light),
      .side_light (side_light),
      .light_t    (light_t),
      .ped_walk   (ped_walk)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic void push(input logic rst, tick, sreq, preq,
                                input logic [2:0] em, es, input int et, input logic ew);
      vec_t v;
      v.rst = rst; v.tick = tick; v.sreq = sreq; v.preq = preq;
      v.em = em; v.es = es; v.et = 4'(et); v.ew = ew;
      vq.push_back(v);
   endfunction

   // Ticks inside a phase of length d, observing d-1 down to 1.
   function automatic void cnt(input logic [2:0] m, s, input int d, input logic w, input logic sq);
      for (int i = d - 1; i >= 1; i--) push(1'b0, 1'b1, sq, 1'b0, m, s, i, w);
   endfunction

   // From MAIN_Y entry through the side phases back to MAIN_G entry.
   function automatic void tail(input logic w, input logic sq_g, input logic sq_y);
      cnt(Y, R, 3, 1'b0, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, R, R, 2, 1'b0);
      cnt(R, R, 2, 1'b0, 1'b0);
      push(1'b0, 1'b1, sq_g, 1'b0, R, G, 8, w);
      cnt(R, G, 8, w, sq_g);
      push(1'b0, 1'b1, sq_g, 1'b0, R, Y, 3, 1'b0);
      cnt(R, Y, 3, 1'b0, sq_y);
      push(1'b0, 1'b1, sq_y, 1'b0, R, R, 2, 1'b0);
      cnt(R, R, 2, 1'b0, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, G, R, 10, 1'b0);
   endfunction

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d actual=%0h required=%0h", name, k, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int k);
      @(negedge sys_clk);
      sys_rst_p = v.rst; tick_1s = v.tick; side_req = v.sreq; ped_req = v.preq;
      @(posedge sys_clk);
      #1;
      chk("main_light", k, 32'(main_light), 32'(v.em));
      chk("side_light", k, 32'(side_light), 32'(v.es));
      chk("light_t",    k, 32'(light_t),    32'(v.et));
      chk("ped_walk",   k, 32'(ped_walk),   32'(v.ew));
   endtask

   initial begin
      vec_t hv;

      // Reset, startup clearance and main green resting with no requests.
      push(1'b1, 1'b0, 1'b0, 1'b0, R, R, 2, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, R, R, 1, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, G, R, 10, 1'b0);
      cnt(G, R, 10, 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) push(1'b0, 1'b1, 1'b0, 1'b0, G, R, 1, 1'b0);

      // Side request pulse at light_t 6, full cycle back to MAIN_G.
      push(1'b1, 1'b0, 1'b0, 1'b0, R, R, 2, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, R, R, 1, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, G, R, 10, 1'b0);
      for (int i = 9; i >= 6; i--) push(1'b0, 1'b1, 1'b0, 1'b0, G, R, i, 1'b0);
      push(1'b0, 1'b0, 1'b1, 1'b0, G, R, 6, 1'b0);
      cnt(G, R, 6, 1'b0, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, Y, R, 3, 1'b0);
      tail(1'b0, 1'b0, 1'b0);

      // Pedestrian request in the same cycle as the final main-green tick.
      cnt(G, R, 10, 1'b0, 1'b0);
`ifdef PED_WALK_EN
      push(1'b0, 1'b1, 1'b0, 1'b1, Y, R, 3, 1'b0);
      tail(1'b1, 1'b0, 1'b0);
      cnt(G, R, 10, 1'b0, 1'b0);
`else
      push(1'b0, 1'b1, 1'b0, 1'b1, G, R, 1, 1'b0);
      for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 1'b0, 1'b0, G, R, 1, 1'b0);
`endif

      // Side request held only through SIDE_G must not re-latch.
      push(1'b0, 1'b1, 1'b1, 1'b0, Y, R, 3, 1'b0);
      tail(1'b0, 1'b1, 1'b0);
      cnt(G, R, 10, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 1'b0, 1'b0, G, R, 1, 1'b0);

      // Request during SIDE_Y stays latched; next exit after exactly 10 ticks.
      push(1'b0, 1'b0, 1'b1, 1'b0, G, R, 1, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, Y, R, 3, 1'b0);
      tail(1'b0, 1'b0, 1'b1);
      cnt(G, R, 10, 1'b0, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, Y, R, 3, 1'b0);

      // Reset with tick mid SIDE_G clears pending requests.
      cnt(Y, R, 3, 1'b0, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, R, R, 2, 1'b0);
      cnt(R, R, 2, 1'b0, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, R, G, 8, 1'b0);
      push(1'b0, 1'b1, 1'b1, 1'b1, R, G, 7, 1'b0);
      push(1'b1, 1'b1, 1'b1, 1'b1, R, R, 2, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, R, R, 1, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, G, R, 10, 1'b0);
      cnt(G, R, 10, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) push(1'b0, 1'b1, 1'b0, 1'b0, G, R, 1, 1'b0);

      for (int k = 0; k < vq.size(); k++) apply(vq[k], k);

      // No tick: everything holds, and a request latched between ticks
      // still triggers the exit on the following tick.
      hv.rst = 1'b0; hv.tick = 1'b0; hv.sreq = 1'b0; hv.preq = 1'b0;
      hv.em = G; hv.es = R; hv.et = 4'd1; hv.ew = 1'b0;
      for (int i = 0; i < 4; i++) apply(hv, 1000 + i);
      hv.sreq = 1'b1;
      apply(hv, 1004);
      hv.sreq = 1'b0;
      for (int i = 0; i < 3; i++) apply(hv, 1005 + i);
      hv.tick = 1'b1; hv.em = Y; hv.et = 4'd3;
      apply(hv, 1008);
      hv.em = Y; hv.et = 4'd2;
      apply(hv, 1009);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
